ticket_change_dispenser: RTL and testbench
==========================================

Name: ticket_change_dispenser

Overview:
Payout end of the ticket vending flow. Accepts one dispense order (ticket count plus change amount) from the fare/payment controller. It issues tickets one at a time to the ticket printer, then pays change as individual coins to the coin hopper. Both outputs use valid/ready handshakes, and coins are chosen greedily from the largest denomination down.

Parameters:
CHANGE_W, 7, width of the change amount and remaining-change register
TICKET_W, 3, width of the ticket count
MAX_TICKETS, 5, largest legal ticket count per order

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
start  input  1  order strobe; sampled only in IDLE
tickets_in  input  TICKET_W  tickets to issue
change_in  input  CHANGE_W  change to pay, in units of 1
ticket_valid  output  1  ticket request to printer
ticket_ready  input  1  printer accepts ticket
coin_valid  output  1  coin request to hopper
coin_ready  input  1  hopper accepts coin
coin_value  output  6  denomination of current coin: 50, 10, 5 or 1; 0 when idle
busy  output  1  order in progress
done  output  1  one-cycle pulse when the order completes
err  output  1  one-cycle pulse when an order is rejected

Behaviour:
- Reset: state IDLE. ticket_valid, coin_valid, coin_value, busy, done and err are all 0. Internal counters are cleared.
- Reset mid-operation: aborts the order at that edge. Outputs take their reset values the next cycle, and the remaining tickets and change are discarded.
- States: IDLE, TICKET, COIN, DONE.
- IDLE, start=1, tickets_in > MAX_TICKETS:
  - err=1 for the next cycle.
  - Stays in IDLE and nothing is latched.
- IDLE, start=1, order legal:
  - Latches tickets_left and change_left; busy=1 from the next cycle.
  - Next state is TICKET if tickets_in>0, else COIN if change_in>0, else DONE.
- TICKET:
  - ticket_valid=1.
  - A transfer is ticket_valid && ticket_ready at a clock edge; it decrements tickets_left.
  - After the transfer that takes tickets_left to 0, next state is COIN if change_left>0, else DONE.
- COIN:
  - coin_valid=1. coin_value is the largest of {50,10,5,1} that is <= change_left.
  - coin_value is a function of registered change_left, so it stays stable while coin_ready is low.
  - A transfer subtracts coin_value from change_left. When the result is 0, next state is DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - A ready input is ignored while its valid is low.
  - A valid signal never drops without a transfer, except on reset.
  - Tickets and coins are never valid in the same cycle.
- start is ignored while busy. No order queuing.
- Latency:
  - start sampled at edge N gives the first valid at cycle N+1.
  - With ready held high, one item transfers per cycle.
  - Total cycles from start to done = tickets + coins + 1.
- Width: change_left never underflows (greedy rule). Maximum change 127 = 50+50+10+10+5+1+1, i.e. 7 coins.

Optional Feature:
Macro DISPENSER_STATS_EN.
- Defined:
  - Adds outputs stat_tickets[15:0] and stat_coins[15:0], cumulative counts of ticket and coin transfers.
  - Each counter increments on a transfer and saturates at 16'hFFFF.
  - Both are cleared by reset only.
- Undefined: these ports and counters do not exist, and the block's behaviour is otherwise identical.

Test Plan:
- start, tickets_in=2, change_in=0, both readies=1 -> ticket_valid at cycles 1-2, coin_valid never, done=1 at cycle 3, busy=0 at cycle 4.
- tickets_in=0, change_in=67, coin_ready=1 -> coin_value sequence 50,10,5,1,1; done the cycle after the 5th transfer.
- tickets_in=1, change_in=127 -> one ticket, then coins 50,50,10,10,5,1,1; done at cycle 9 after start.
- change_in=55, coin_ready low 3 cycles after coin_valid rises -> coin_valid=1 and coin_value=50 held stable all 3 cycles; 5 follows after the transfer.
- tickets_in=6 -> err pulse 1 cycle, busy stays 0, no valids. A second start arriving while busy must be ignored.
- reset asserted in COIN after 1 of 3 coins -> coin_valid=0 and busy=0 next cycle; a new order then runs cleanly. With DISPENSER_STATS_EN defined, the stat counters read 0 after reset.

Source files
------------

// File: rtl/ticket_change_dispenser.sv
// rtl/ticket_change_dispenser.sv - ticket and greedy coin-change payout engine
//
// Purpose: accepts one dispense order (ticket count + change amount), issues
// tickets one at a time to the printer, then pays change to the coin hopper
// as single coins chosen greedily from {50,10,5,1}.
//
// Optional feature: define DISPENSER_STATS_EN to add cumulative saturating
// transfer counters stat_tickets / stat_coins.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start             order strobe, sampled only while idle
//   tickets_in        tickets to issue (legal range 0..MAX_TICKETS)
//   change_in         change to pay, in units of 1
//   ticket_valid/ready  ticket handshake to printer
//   coin_valid/ready    coin handshake to hopper
//   coin_value        denomination of the current coin, 0 when not paying
//   busy              order in progress (including the done cycle)
//   done              one-cycle pulse on order completion
//   err               one-cycle pulse when an order is rejected
//   stat_tickets/coins  (DISPENSER_STATS_EN only) cumulative transfer counts

module ticket_change_dispenser #(
  parameter int CHANGE_W    = 7,
  parameter int TICKET_W    = 3,
  parameter int MAX_TICKETS = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [TICKET_W-1:0] tickets_in,
  input  logic [CHANGE_W-1:0] change_in,
  output logic                ticket_valid,
  input  logic                ticket_ready,
  output logic                coin_valid,
  input  logic                coin_ready,
  output logic [5:0]          coin_value,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef DISPENSER_STATS_EN
  ,
  output logic [15:0]         stat_tickets,
  output logic [15:0]         stat_coins
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TICKET = 2'd1,
    S_COIN   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TICKET_W-1:0] tickets_left_q, tickets_left_d;
  logic [CHANGE_W-1:0] change_left_q, change_left_d;
  logic                err_q, err_d;

  // Greedy denomination; derived from registered change_left so the coin
  // offered to the hopper cannot change while it is stalling.
  logic [5:0]          coin_sel;
  logic [CHANGE_W-1:0] coin_amt;

  always_comb begin
    if (change_left_q >= CHANGE_W'(50)) begin
      coin_sel = 6'd50;
    end else if (change_left_q >= CHANGE_W'(10)) begin
      coin_sel = 6'd10;
    end else if (change_left_q >= CHANGE_W'(5)) begin
      coin_sel = 6'd5;
    end else begin
      coin_sel = 6'd1;
    end
    coin_amt = CHANGE_W'(coin_sel);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tickets_left_q <= '0;
      change_left_q  <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      tickets_left_q <= tickets_left_d;
      change_left_q  <= change_left_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    tickets_left_d = tickets_left_q;
    change_left_d  = change_left_q;
    err_d          = 1'b0;
    ticket_valid   = 1'b0;
    coin_valid     = 1'b0;
    coin_value     = 6'd0;
    busy           = 1'b1;
    done           = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (tickets_in > TICKET_W'(MAX_TICKETS)) begin
            err_d = 1'b1;
          end else begin
            tickets_left_d = tickets_in;
            change_left_d  = change_in;
            if (tickets_in != '0) begin
              state_d = S_TICKET;
            end else if (change_in != '0) begin
              state_d = S_COIN;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end

      S_TICKET: begin
        ticket_valid = 1'b1;
        if (ticket_ready) begin
          tickets_left_d = tickets_left_q - TICKET_W'(1);
          if (tickets_left_q == TICKET_W'(1)) begin
            state_d = (change_left_q != '0) ? S_COIN : S_DONE;
          end
        end
      end

      S_COIN: begin
        coin_valid = 1'b1;
        coin_value = coin_sel;
        if (coin_ready) begin
          // coin_amt <= change_left_q by construction, so no underflow.
          change_left_d = change_left_q - coin_amt;
          if (change_left_d == '0) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign err = err_q;

`ifdef DISPENSER_STATS_EN
  logic [15:0] stat_tickets_q;
  logic [15:0] stat_coins_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_tickets_q <= 16'h0000;
      stat_coins_q   <= 16'h0000;
    end else begin
      if (ticket_valid && ticket_ready && (stat_tickets_q != 16'hFFFF)) begin
        stat_tickets_q <= stat_tickets_q + 16'd1;
      end
      if (coin_valid && coin_ready && (stat_coins_q != 16'hFFFF)) begin
        stat_coins_q <= stat_coins_q + 16'd1;
      end
    end
  end

  assign stat_tickets = stat_tickets_q;
  assign stat_coins   = stat_coins_q;
`endif

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// tb/tb_ticket_change_dispenser.sv - directed self-checking bench for ticket_change_dispenser

module tb_ticket_change_dispenser;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] tickets_in;
  logic [6:0] change_in;
  logic       ticket_valid;
  logic       ticket_ready;
  logic       coin_valid;
  logic       coin_ready;
  logic [5:0] coin_value;
  logic       busy;
  logic       done;
  logic       err;
`ifdef DISPENSER_STATS_EN
  logic [15:0] stat_tickets;
  logic [15:0] stat_coins;
`endif

  int total = 0;
  int bad   = 0;
  int exp_coins [8];

  ticket_change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tickets_in   (tickets_in),
    .change_in    (change_in),
    .ticket_valid (ticket_valid),
    .ticket_ready (ticket_ready),
    .coin_valid   (coin_valid),
    .coin_ready   (coin_ready),
    .coin_value   (coin_value),
    .busy         (busy),
    .done         (done),
    .err          (err)
`ifdef DISPENSER_STATS_EN
    ,
    .stat_tickets (stat_tickets),
    .stat_coins   (stat_coins)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ticket_valid"}, int'(ticket_valid), 0);
    chk({tag, ".coin_valid"},   int'(coin_valid),   0);
    chk({tag, ".coin_value"},   int'(coin_value),   0);
    chk({tag, ".busy"},         int'(busy),         0);
    chk({tag, ".done"},         int'(done),         0);
    chk({tag, ".err"},          int'(err),          0);
  endtask

  // Runs one legal order with both readies high; exp_coins holds the coin
  // sequence. With inject set, a second start is presented while busy.
  task automatic run_order(input string tag, input int nt, input int ch,
                           input int nc, input bit inject);
    start = 1'b1; tickets_in = 3'(nt); change_in = 7'(ch);
    ticket_ready = 1'b1; coin_ready = 1'b1;
    step();
    start = 1'b0;
    if (inject) begin
      start = 1'b1; tickets_in = 3'd3; change_in = 7'd5;
    end
    for (int i = 0; i < nt; i++) begin
      chk($sformatf("%s.tkt%0d.ticket_valid", tag, i), int'(ticket_valid), 1);
      chk($sformatf("%s.tkt%0d.coin_valid", tag, i),   int'(coin_valid),   0);
      chk($sformatf("%s.tkt%0d.busy", tag, i),         int'(busy),         1);
      step();
      start = 1'b0;
    end
    for (int i = 0; i < nc; i++) begin
      chk($sformatf("%s.coin%0d.coin_valid", tag, i),   int'(coin_valid),   1);
      chk($sformatf("%s.coin%0d.coin_value", tag, i),   int'(coin_value),   exp_coins[i]);
      chk($sformatf("%s.coin%0d.ticket_valid", tag, i), int'(ticket_valid), 0);
      step();
      start = 1'b0;
    end
    chk({tag, ".done"},         int'(done),         1);
    chk({tag, ".done.busy"},    int'(busy),         1);
    chk({tag, ".done.tvalid"},  int'(ticket_valid), 0);
    chk({tag, ".done.cvalid"},  int'(coin_valid),   0);
    step();
    chk_idle({tag, ".after"});
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tickets_in = '0; change_in = '0;
    ticket_ready = 1'b0; coin_ready = 1'b0;
    step(); step();
    chk_idle("reset");
    reset = 1'b0;
    step();
    chk_idle("idle");

    // Two tickets, no change.
    run_order("t2c0", 2, 0, 0, 1'b0);

    // 67 = 50+10+5+1+1.
    exp_coins[0] = 50; exp_coins[1] = 10; exp_coins[2] = 5;
    exp_coins[3] = 1;  exp_coins[4] = 1;
    run_order("t0c67", 0, 67, 5, 1'b0);

    // Maximum change plus a ticket; a start while busy must be ignored.
    exp_coins[0] = 50; exp_coins[1] = 50; exp_coins[2] = 10; exp_coins[3] = 10;
    exp_coins[4] = 5;  exp_coins[5] = 1;  exp_coins[6] = 1;
    run_order("t1c127", 1, 127, 7, 1'b1);

    // Boundaries: MAX_TICKETS legal, empty order goes straight to done.
    run_order("t5c0", 5, 0, 0, 1'b0);
    run_order("t0c0", 0, 0, 0, 1'b0);

    // Hopper stalls on the first coin of 55 = 50+5.
    start = 1'b1; tickets_in = 3'd0; change_in = 7'd55;
    ticket_ready = 1'b1; coin_ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d.coin_valid", i), int'(coin_valid), 1);
      chk($sformatf("stall%0d.coin_value", i), int'(coin_value), 50);
      chk($sformatf("stall%0d.ticket_valid", i), int'(ticket_valid), 0);
      step();
    end
    coin_ready = 1'b1;
    chk("stall.release.coin_value", int'(coin_value), 50);
    step();
    chk("stall.second.coin_valid", int'(coin_valid), 1);
    chk("stall.second.coin_value", int'(coin_value), 5);
    step();
    chk("stall.done", int'(done), 1);
    step();
    chk_idle("stall.after");

    // Illegal ticket counts are rejected with a single err pulse.
    start = 1'b1; tickets_in = 3'd6; change_in = 7'd10;
    step();
    start = 1'b0;
    chk("rej6.err",          int'(err),          1);
    chk("rej6.busy",         int'(busy),         0);
    chk("rej6.ticket_valid", int'(ticket_valid), 0);
    chk("rej6.coin_valid",   int'(coin_valid),   0);
    step();
    chk_idle("rej6.after");
    start = 1'b1; tickets_in = 3'd7; change_in = 7'd0;
    step();
    start = 1'b0;
    chk("rej7.err", int'(err), 1);
    step();
    chk_idle("rej7.after");

    // Reset in the middle of paying 16 = 10+5+1, after the first coin.
    start = 1'b1; tickets_in = 3'd0; change_in = 7'd16;
    step();
    start = 1'b0;
    chk("abort.coin0", int'(coin_value), 10);
    step();
    chk("abort.coin1", int'(coin_value), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_idle("abort.after");
`ifdef DISPENSER_STATS_EN
    chk("abort.stat_tickets", int'(stat_tickets), 0);
    chk("abort.stat_coins",   int'(stat_coins),   0);
`endif
    step();
    chk_idle("abort.idle");

    // Fresh order after the abort: 6 = 5+1.
    exp_coins[0] = 5; exp_coins[1] = 1;
    run_order("post", 1, 6, 2, 1'b0);
`ifdef DISPENSER_STATS_EN
    chk("post.stat_tickets", int'(stat_tickets), 1);
    chk("post.stat_coins",   int'(stat_coins),   2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
